mod_counter: RTL

//   Parametrised modulo up/down counter, the next generation of the lab 8-bit counter.

---
 rtl/mod_counter.sv | 103 ++++++++++
 1 files changed

// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with programmable limit, wrap or
// saturate mode, parallel load, prescaled enable, terminal-count pulse and
// sticky overflow flag. All outputs are registered.
module mod_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int RST_VAL  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_sat,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_clr_ovf,
  output logic [WIDTH-1:0] o_number,
  output logic             o_tc,
  output logic             o_ovf
);

  // Prescaler counter is at least one bit wide so PRESCALE=1 still has a
  // legal register; it then stays at zero and the tick collapses to i_en.
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0]   PS_LAST = PSW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] RST_NUM = WIDTH'(RST_VAL);

  logic [PSW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_number;
  logic             r_tc;
  logic             r_ovf;

  logic             w_tick;
  logic [WIDTH-1:0] w_stepNumber;
  logic             w_boundary;
  logic             w_wrap;

  assign w_tick = i_en && (r_cnt == PS_LAST);

  // Next count value for a tick, plus whether the step hits a bound and
  // whether that bound event is a wrap (which is what sets the sticky flag).
  always_comb begin
    w_stepNumber = r_number;
    w_boundary   = 1'b0;
    w_wrap       = 1'b0;
    if (i_up) begin
      if (r_number < i_limit) begin
        w_stepNumber = r_number + 1'b1;
      end else begin
        w_boundary   = 1'b1;
        w_wrap       = !i_sat;
        w_stepNumber = i_sat ? i_limit : '0;
      end
    end else begin
      if (r_number != '0) begin
        w_stepNumber = r_number - 1'b1;
      end else begin
        w_boundary   = 1'b1;
        w_wrap       = !i_sat;
        w_stepNumber = i_sat ? '0 : i_limit;
      end
    end
  end

  // Count state: reset beats load, load beats a tick, otherwise hold.
  // A wrap in the same cycle as clr_ovf leaves the flag set.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_number <= RST_NUM;
      r_cnt    <= '0;
      r_tc     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (i_load) begin
        r_number <= i_load_val;
        r_cnt    <= '0;
        if (i_clr_ovf) begin
          r_ovf <= 1'b0;
        end
      end else begin
        if (i_en) begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        end
        if (w_tick) begin
          r_number <= w_stepNumber;
          r_tc     <= w_boundary;
        end
        if (w_tick && w_wrap) begin
          r_ovf <= 1'b1;
        end else if (i_clr_ovf) begin
          r_ovf <= 1'b0;
        end
      end
    end
  end

  assign o_number = r_number;
  assign o_tc     = r_tc;
  assign o_ovf    = r_ovf;

endmodule
